// File: rtl/wb_port_scheduler.sv
// Write-back port scheduler: one pending write buffered per source, granted
// round-robin onto the single register-file write port, one write per cycle.
module wb_port_scheduler #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [2:0]        req_valid,
  output logic [2:0]        req_ready,
  input  logic [4:0]        req_addr0,
  input  logic [4:0]        req_addr1,
  input  logic [4:0]        req_addr2,
  input  logic [DATA_W-1:0] req_data0,
  input  logic [DATA_W-1:0] req_data1,
  input  logic [DATA_W-1:0] req_data2,
  output logic [1:0]        sel,
  output logic              rf_we,
  output logic [4:0]        rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [2:0]        pending
);

  logic [2:0]        pend_r;
  logic [4:0]        addr_r [3];
  logic [DATA_W-1:0] data_r [3];
  logic [1:0]        rr_r;

  logic [4:0]        in_addr_s [3];
  logic [DATA_W-1:0] in_data_s [3];
  logic [2:0]        rot_s;
  logic [2:0]        pick_s;
  logic [2:0]        grant_s;
  logic [1:0]        gidx_s;
  logic [1:0]        rr_next_s;
  logic [2:0]        accept_s;
  logic [4:0]        gaddr_s;
  logic [DATA_W-1:0] gdata_s;

  assign in_addr_s[0] = req_addr0;
  assign in_addr_s[1] = req_addr1;
  assign in_addr_s[2] = req_addr2;
  assign in_data_s[0] = req_data0;
  assign in_data_s[1] = req_data1;
  assign in_data_s[2] = req_data2;

  assign req_ready = ~pend_r | grant_s;
  assign pending   = pend_r;

  // Rotate pend so the rr source is bit 0, pick the lowest set bit, rotate back.
  always_comb begin
    rot_s   = pend_r;
    pick_s  = 3'b000;
    grant_s = 3'b000;
    case (rr_r)
      2'd1:    rot_s = {pend_r[0], pend_r[2], pend_r[1]};
      2'd2:    rot_s = {pend_r[1], pend_r[0], pend_r[2]};
      default: rot_s = pend_r;
    endcase
    if (rot_s[0]) begin
      pick_s = 3'b001;
    end else if (rot_s[1]) begin
      pick_s = 3'b010;
    end else if (rot_s[2]) begin
      pick_s = 3'b100;
    end else begin
      pick_s = 3'b000;
    end
    case (rr_r)
      2'd1:    grant_s = {pick_s[1], pick_s[0], pick_s[2]};
      2'd2:    grant_s = {pick_s[0], pick_s[2], pick_s[1]};
      default: grant_s = pick_s;
    endcase
  end

  // Granted index, its buffered entry, and the pointer value that follows it.
  always_comb begin
    gidx_s    = 2'd0;
    rr_next_s = 2'd1;
    gaddr_s   = addr_r[0];
    gdata_s   = data_r[0];
    case (grant_s)
      3'b010: begin
        gidx_s    = 2'd1;
        rr_next_s = 2'd2;
        gaddr_s   = addr_r[1];
        gdata_s   = data_r[1];
      end
      3'b100: begin
        gidx_s    = 2'd2;
        rr_next_s = 2'd0;
        gaddr_s   = addr_r[2];
        gdata_s   = data_r[2];
      end
      default: begin
        gidx_s    = 2'd0;
        rr_next_s = 2'd1;
        gaddr_s   = addr_r[0];
        gdata_s   = data_r[0];
      end
    endcase
  end

  // Address-0 transfers complete the handshake but never occupy a buffer.
  always_comb begin
    accept_s = 3'b000;
    for (int i = 0; i < 3; i++) begin
      accept_s[i] = req_valid[i] & req_ready[i] & (in_addr_s[i] != 5'd0);
    end
  end

  // Pending buffers and round-robin pointer; a same-cycle accept wins over grant clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_r <= 3'b000;
      rr_r   <= 2'd0;
      for (int i = 0; i < 3; i++) begin
        addr_r[i] <= 5'd0;
        data_r[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (accept_s[i]) begin
          pend_r[i] <= 1'b1;
          addr_r[i] <= in_addr_s[i];
          data_r[i] <= in_data_s[i];
        end else if (grant_s[i]) begin
          pend_r[i] <= 1'b0;
        end
      end
      if (|grant_s) begin
        rr_r <= rr_next_s;
      end
    end
  end

  // Registered write port; sel/addr/data only move together with a new write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we    <= 1'b0;
      sel      <= 2'd0;
      rf_waddr <= 5'd0;
      rf_wdata <= '0;
    end else if (|grant_s) begin
      rf_we    <= 1'b1;
      sel      <= gidx_s;
      rf_waddr <= gaddr_s;
      rf_wdata <= gdata_s;
    end else begin
      rf_we <= 1'b0;
    end
  end

endmodule
